dma_priority_arbiter: RTL and testbench

- Parametrised DMA channel priority arbiter and bus-request sequencer. It is the next generation of the fixed 4-channel priority block.
- It collects hardware DREQs and software requests for NCH channels and applies mask, polarity and controller-disable controls.
- It runs the HRQ/HLDA handshake as a state machine, asserts one DACK at a time, and muxes the winning channel's address onto ch_out.
- It sits between the command/mask/request registers and the transfer engine that generates tc.

---
 rtl/dma_arb_if.sv | 33 +++
 rtl/dma_priority_arbiter.sv | 169 ++++++++++++++++
 tb/tb_dma_priority_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_arb_if.sv
// Request/acknowledge and address bus bundle between the DMA register file,
// the channel arbiter (slave) and the transfer engine / CPU side (master).
interface dma_arb_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned AW  = 16
);
    localparam int unsigned CHW = $clog2(NCH);

    logic [NCH-1:0]    dreq;
    logic [NCH-1:0]    mask;
    logic [NCH-1:0]    sw_req;
    logic              hlda;
    logic              tc;
    logic              svc_end;
    logic [NCH*AW-1:0] ch_addr;

    logic              hrq;
    logic [NCH-1:0]    dack;
    logic [AW-1:0]     ch_out;
    logic [CHW-1:0]    act_ch;
    logic              active;
    logic [NCH-1:0]    sw_req_clr;

    modport slave (
        input  dreq, mask, sw_req, hlda, tc, svc_end, ch_addr,
        output hrq, dack, ch_out, act_ch, active, sw_req_clr
    );

    modport master (
        output dreq, mask, sw_req, hlda, tc, svc_end, ch_addr,
        input  hrq, dack, ch_out, act_ch, active, sw_req_clr
    );
endinterface

// File: rtl/dma_priority_arbiter.sv
// DMA channel priority arbiter with HRQ/HLDA bus-request sequencing.
// Define DMA_ARB_ROTATE_EN to enable rotating priority under rot_pri.
module dma_priority_arbiter #(
    parameter int unsigned NCH = 4,
    parameter int unsigned AW  = 16
) (
    input  logic      clk,
    input  logic      Reset,
    input  logic      dreq_sense,
    input  logic      dack_sense,
    input  logic      ctrl_dis,
    input  logic      rot_pri,
    dma_arb_if.slave  bus
);
    localparam int unsigned CHW = $clog2(NCH);

    typedef enum logic [1:0] {IDLE, REQ, SERVE, RELEASE} state_e;

    state_e         state_q, state_d;
    logic           hrq_q, hrq_d;
    logic [NCH-1:0] dack_q, dack_d;
    logic [AW-1:0]  ch_out_q, ch_out_d;
    logic [CHW-1:0] act_ch_q, act_ch_d;
    logic           active_q, active_d;
    logic [NCH-1:0] clr_q, clr_d;

    logic [NCH-1:0] pending;
    logic [AW-1:0]  addr_arr [NCH];
    logic [CHW-1:0] arb_base;
    logic [CHW-1:0] win_idx;
    logic           win_vld;

    always_comb begin
        pending = ((bus.dreq ^ {NCH{dreq_sense}}) & ~bus.mask) | bus.sw_req;
    end

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            addr_arr[i] = bus.ch_addr[i*AW +: AW];
        end
    end

`ifdef DMA_ARB_ROTATE_EN
    logic [CHW-1:0] ptr_q, ptr_d;
    logic [CHW-1:0] ptr_next;

    assign arb_base = rot_pri ? ptr_q : '0;
    assign ptr_next = (act_ch_q == CHW'(NCH - 1)) ? '0 : act_ch_q + 1'b1;

    // Served channel drops to lowest priority on any exit from SERVE.
    always_comb begin
        ptr_d = ptr_q;
        if (!rot_pri) begin
            ptr_d = '0;
        end else if (state_q == SERVE && state_d != SERVE) begin
            ptr_d = ptr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic rot_pri_unused;

    assign rot_pri_unused = rot_pri;
    assign arb_base       = '0;
`endif

    // Search upward from arb_base, wrapping past NCH-1 back to channel 0.
    always_comb begin
        logic [CHW-1:0] cand;
        cand    = '0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (32'(arb_base) + k >= NCH) begin
                cand = CHW'(32'(arb_base) + k - NCH);
            end else begin
                cand = CHW'(32'(arb_base) + k);
            end
            if (!win_vld && pending[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        act_ch_d = act_ch_q;
        ch_out_d = ch_out_q;
        clr_d    = '0;

        unique case (state_q)
            IDLE: begin
                if (!ctrl_dis && |pending) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.hlda) begin
                    if (win_vld) begin
                        state_d  = SERVE;
                        act_ch_d = win_idx;
                        ch_out_d = addr_arr[win_idx];
                    end else begin
                        state_d = RELEASE;
                    end
                end
            end
            SERVE: begin
                if (!bus.hlda) begin
                    state_d = IDLE;
                end else if (bus.tc) begin
                    state_d         = RELEASE;
                    clr_d[act_ch_q] = bus.sw_req[act_ch_q];
                end else if (bus.svc_end || !pending[act_ch_q]) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!bus.hlda) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        hrq_d    = (state_d == REQ) || (state_d == SERVE);
        active_d = (state_d == SERVE);
        dack_d   = {NCH{dack_sense}};
        if (state_d == SERVE) begin
            dack_d[act_ch_d] = ~dack_sense;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            hrq_q    <= 1'b0;
            dack_q   <= {NCH{dack_sense}};
            ch_out_q <= '0;
            act_ch_q <= '0;
            active_q <= 1'b0;
            clr_q    <= '0;
        end else begin
            state_q  <= state_d;
            hrq_q    <= hrq_d;
            dack_q   <= dack_d;
            ch_out_q <= ch_out_d;
            act_ch_q <= act_ch_d;
            active_q <= active_d;
            clr_q    <= clr_d;
        end
    end

    assign bus.hrq        = hrq_q;
    assign bus.dack       = dack_q;
    assign bus.ch_out     = ch_out_q;
    assign bus.act_ch     = act_ch_q;
    assign bus.active     = active_q;
    assign bus.sw_req_clr = clr_q;
endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter: directed scenarios plus
// randomized traffic, all compared against a channel-ownership reference model.
module tb_dma_priority_arbiter;
    localparam int unsigned NCH = 4;
    localparam int unsigned AW  = 16;
`ifdef DMA_ARB_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic clk = 1'b0;
    logic Reset;
    logic dreq_sense, dack_sense, ctrl_dis, rot_pri;

    dma_arb_if #(.NCH(NCH), .AW(AW)) bus ();

    dma_priority_arbiter #(.NCH(NCH), .AW(AW)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .dreq_sense (dreq_sense),
        .dack_sense (dack_sense),
        .ctrl_dis   (ctrl_dis),
        .rot_pri    (rot_pri),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: who owns the bus, whether we are asking for it,
    // and whether we are waiting for the CPU to take hlda away.
    bit             armed = 1'b0;
    int             m_owner = -1;
    bit             m_ask, m_drain, m_ds;
    int             m_act, m_ptr;
    logic [AW-1:0]  m_chout;
    logic [NCH-1:0] m_clr;

    function automatic logic [NCH-1:0] pend_now();
        logic [NCH-1:0] p;
        for (int i = 0; i < NCH; i++) begin
            p[i] = ((bus.dreq[i] != dreq_sense) && !bus.mask[i]) || bus.sw_req[i];
        end
        return p;
    endfunction

    function automatic int pick(input logic [NCH-1:0] p, input int base);
        for (int k = 0; k < NCH; k++) begin
            if (p[(base + k) % NCH]) return (base + k) % NCH;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [NCH-1:0] p;
        int w;
        p     = pend_now();
        m_ds  = dack_sense;
        m_clr = '0;
        if (Reset) begin
            armed = 1'b1; m_owner = -1; m_ask = 0; m_drain = 0;
            m_act = 0; m_ptr = 0; m_chout = '0;
        end else if (m_owner >= 0) begin
            bit left = 1'b1;
            if (!bus.hlda) begin
                m_drain = 0;
            end else if (bus.tc) begin
                m_clr[m_owner] = bus.sw_req[m_owner];
                m_drain = 1;
            end else if (bus.svc_end || !p[m_owner]) begin
                m_drain = 1;
            end else begin
                left = 1'b0;
            end
            if (left) begin
                m_ptr   = (m_owner + 1) % NCH;
                m_owner = -1;
            end
        end else if (m_drain) begin
            if (!bus.hlda) m_drain = 0;
        end else if (m_ask) begin
            if (bus.hlda) begin
                m_ask = 0;
                w = pick(p, (ROT && rot_pri) ? m_ptr : 0);
                if (w >= 0) begin
                    m_owner = w; m_act = w;
                    m_chout = bus.ch_addr[w*AW +: AW];
                end else begin
                    m_drain = 1;
                end
            end
        end else if (!ctrl_dis && p != '0) begin
            m_ask = 1;
        end
        if (!rot_pri) m_ptr = 0;
    endtask

    task automatic compare_model();
        logic [NCH-1:0] d;
        d = {NCH{m_ds}};
        if (m_owner >= 0) d[m_owner] = ~m_ds;
        check_eq("m_hrq",    64'(bus.hrq),        64'(m_ask || m_owner >= 0));
        check_eq("m_dack",   64'(bus.dack),       64'(d));
        check_eq("m_active", 64'(bus.active),     64'(m_owner >= 0));
        check_eq("m_act_ch", 64'(bus.act_ch),     64'(m_act));
        check_eq("m_ch_out", 64'(bus.ch_out),     64'(m_chout));
        check_eq("m_clr",    64'(bus.sw_req_clr), 64'(m_clr));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        if (armed) compare_model();
    endtask

    task automatic clear_bus();
        bus.dreq = '0; bus.mask = '0; bus.sw_req = '0;
        bus.hlda = 0; bus.tc = 0; bus.svc_end = 0;
        ctrl_dis = 0; rot_pri = 0;
    endtask

    task automatic do_reset();
        Reset = 1; step(); step(); Reset = 0;
    endtask

    task automatic wait_hrq();
        for (int i = 0; i < 20 && !bus.hrq; i++) step();
        check_eq("hrq_wait", 64'(bus.hrq), 64'd1);
    endtask

    task automatic get_grant();
        wait_hrq(); bus.hlda = 1; step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        Reset = 1; dreq_sense = 0; dack_sense = 0;
        clear_bus();
        for (int i = 0; i < NCH; i++) bus.ch_addr[i*AW +: AW] = AW'(16'hA000 + 16'h1001 * i);
        do_reset();
        check_eq("rst_dack", 64'(bus.dack), 64'h0);
        check_eq("rst_hrq",  64'(bus.hrq),  64'h0);

        // Fixed priority, hlda two cycles after hrq
        bus.dreq = 4'b1010;
        wait_hrq(); step(); step(); bus.hlda = 1; step();
        check_eq("s1_dack", 64'(bus.dack),   64'b0010);
        check_eq("s1_act",  64'(bus.act_ch), 64'd1);
        check_eq("s1_addr", 64'(bus.ch_out), 64'hB001);
        bus.tc = 1; bus.dreq = 4'b1000; step(); bus.tc = 0;
        check_eq("s1_clr",  64'(bus.sw_req_clr), 64'h0);
        check_eq("s1_rel",  64'(bus.hrq),        64'h0);
        bus.hlda = 0; step();
        get_grant();
        check_eq("s1_ch3",  64'(bus.act_ch), 64'd3);

        // Mask vs software request
        clear_bus(); do_reset();
        bus.mask = 4'b1111; bus.dreq = 4'b1111; bus.sw_req = 4'b0100;
        get_grant();
        check_eq("s2_dack", 64'(bus.dack), 64'b0100);
        bus.tc = 1; step(); bus.tc = 0;
        check_eq("s2_clr",  64'(bus.sw_req_clr), 64'b0100);
        bus.sw_req = '0; step();
        check_eq("s2_clr1", 64'(bus.sw_req_clr), 64'b0000);

        // Polarity
        clear_bus(); dreq_sense = 1; dack_sense = 1; bus.dreq = 4'b1111;
        do_reset();
        check_eq("s3_rstdack", 64'(bus.dack), 64'b1111);
        bus.dreq = 4'b1110;
        get_grant();
        check_eq("s3_dack", 64'(bus.dack),   64'b1110);
        check_eq("s3_act",  64'(bus.act_ch), 64'd0);
        dreq_sense = 0; dack_sense = 0;

        // Request withdrawn before hlda
        clear_bus(); do_reset();
        bus.dreq = 4'b0001; wait_hrq();
        bus.dreq = 4'b0000; bus.hlda = 1; step();
        check_eq("s4_noact",  64'(bus.active), 64'd0);
        check_eq("s4_nodack", 64'(bus.dack),   64'h0);
        bus.hlda = 0; step();

        // Bus lost together with tc
        clear_bus(); do_reset();
        bus.sw_req = 4'b0001; get_grant();
        check_eq("s4b_act", 64'(bus.active), 64'd1);
        bus.hlda = 0; bus.tc = 1; step(); bus.tc = 0;
        check_eq("s4b_hrq",  64'(bus.hrq),        64'h0);
        check_eq("s4b_dack", 64'(bus.dack),       64'h0);
        check_eq("s4b_clr",  64'(bus.sw_req_clr), 64'h0);

        // Rotation order, then fixed with rot_pri low
        clear_bus(); do_reset();
        rot_pri = 1; bus.dreq = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            if (k == 5) rot_pri = 0;
            get_grant();
            check_eq("rot_order", 64'(bus.act_ch), 64'((ROT && k < 5) ? k % NCH : 0));
            bus.svc_end = 1; step(); bus.svc_end = 0;
            bus.hlda = 0; step();
        end

        // Reset mid-SERVE, then ctrl_dis
        clear_bus(); do_reset();
        bus.sw_req = 4'b0010; get_grant();
        Reset = 1; step(); Reset = 0; bus.hlda = 0; bus.sw_req = '0;
        check_eq("s6_hrq",    64'(bus.hrq),    64'h0);
        check_eq("s6_dack",   64'(bus.dack),   64'h0);
        check_eq("s6_chout",  64'(bus.ch_out), 64'h0);
        check_eq("s6_act",    64'(bus.act_ch), 64'h0);
        check_eq("s6_active", 64'(bus.active), 64'h0);
        ctrl_dis = 1; bus.dreq = 4'b0001;
        for (int i = 0; i < 5; i++) step();
        check_eq("s6_dis", 64'(bus.hrq), 64'h0);

        // Randomized traffic
        clear_bus(); do_reset();
        for (int c = 0; c < 4000; c++) begin
            step();
            bus.tc = 0; bus.svc_end = 0; Reset = 0;
            bus.sw_req = bus.sw_req & ~bus.sw_req_clr;
            if ($urandom_range(3) == 0)  bus.dreq = NCH'($urandom);
            if ($urandom_range(15) == 0) bus.mask = NCH'($urandom & $urandom);
            if ($urandom_range(19) == 0) bus.sw_req[$urandom_range(NCH-1)] = 1'b1;
            if (bus.hrq && !bus.hlda && $urandom_range(2) == 0)      bus.hlda = 1;
            else if (!bus.hrq && bus.hlda && $urandom_range(1) == 0) bus.hlda = 0;
            else if (bus.hlda && $urandom_range(39) == 0)            bus.hlda = 0;
            if (bus.active && $urandom_range(7) == 0) bus.tc = 1;
            if (bus.active && $urandom_range(9) == 0) bus.svc_end = 1;
            if ($urandom_range(29) == 0)  ctrl_dis   = ~ctrl_dis;
            if ($urandom_range(99) == 0)  rot_pri    = ~rot_pri;
            if ($urandom_range(199) == 0) dreq_sense = ~dreq_sense;
            if ($urandom_range(199) == 0) dack_sense = ~dack_sense;
            if ($urandom_range(49) == 0) begin
                for (int i = 0; i < NCH; i++) bus.ch_addr[i*AW +: AW] = AW'($urandom);
            end
            if ($urandom_range(299) == 0) Reset = 1;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
